// File: rtl/key_checker_pkg.sv
// Shared types and sizing helpers for the sequential key checker.
// State encoding, default geometry and the counter-width helper live here
// so the top, the interface and the lockout timer all agree on them.
package key_checker_pkg;

  typedef enum logic [1:0] {
    RECEIVE = 2'd0,
    COMPARE = 2'd1,
    RESULT  = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam int DEF_NUM_SYMS       = 4;
  localparam int DEF_SYM_W          = 2;
  localparam int DEF_CYCLES_PER_SYM = 1;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_w(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_checker_seq_if.sv
// Symbol / key / result bundle between the button receiver side and the
// key checker. Handshake: sym_valid and ack are single-cycle strobes with no
// ready; a symbol is taken on the rising edge where sym_valid is high and the
// checker is collecting, and is silently dropped in any other state.
interface key_checker_seq_if
  import key_checker_pkg::*;
#(
  parameter int NUM_SYMS  = DEF_NUM_SYMS,
  parameter int SYM_W     = DEF_SYM_W,
  parameter int MAX_FAILS = 3
);
  localparam int SC_W = cnt_w(NUM_SYMS);
  localparam int FC_W = cnt_w(MAX_FAILS);

  logic                      sym_valid;
  logic [SYM_W-1:0]          sym;
  logic [NUM_SYMS*SYM_W-1:0] key;
  logic                      ack;
  logic                      success;
  logic                      fail;
  logic                      busy;
  logic                      locked;
  logic [SC_W-1:0]           sym_count;
  logic [FC_W-1:0]           fail_count;

  modport master (
    output sym_valid, sym, key, ack,
    input  success, fail, busy, locked, sym_count, fail_count
  );

  modport slave (
    input  sym_valid, sym, key, ack,
    output success, fail, busy, locked, sym_count, fail_count
  );
endinterface

// File: rtl/key_checker_seq_lockout_timer.sv
// Lockout down-counter. A start strobe loads LOCKOUT_CYCLES; active stays
// high while the count is non-zero and done marks the final active cycle.
module lockout_timer
  import key_checker_pkg::*;
#(
  parameter int LOCKOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic active,
  output logic done
);
  localparam int CW = cnt_w(LOCKOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  // Load on start, otherwise count down to zero and stop.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CW'(LOCKOUT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register, cleared by asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign active = (cnt_q != '0);
  assign done   = (cnt_q == CW'(1));

endmodule

// File: rtl/key_checker_seq.sv
// Sequential key checker: collects NUM_SYMS symbols, compares them against a
// key snapshot one symbol every CYCLES_PER_SYM clocks, holds success/fail
// until ack, and locks out after MAX_FAILS consecutive failures.
// Build option: KEY_CHECKER_CONST_TIME_EN selects constant-time comparison
// (all symbols always walked, sticky mismatch flag); when undefined the
// comparison exits at the first mismatching symbol.
module key_checker_seq
  import key_checker_pkg::*;
#(
  parameter int NUM_SYMS       = DEF_NUM_SYMS,
  parameter int SYM_W          = DEF_SYM_W,
  parameter int CYCLES_PER_SYM = DEF_CYCLES_PER_SYM,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  key_checker_seq_if.slave  bus,
  output state_t            dbg_state
);
  localparam int KEY_W = NUM_SYMS * SYM_W;
  localparam int SC_W  = cnt_w(NUM_SYMS);
  localparam int FC_W  = cnt_w(MAX_FAILS);
  localparam int IDX_W = cnt_w(NUM_SYMS - 1);
  localparam int SUB_W = cnt_w(CYCLES_PER_SYM - 1);

  state_t            state_q, state_d;
  logic [KEY_W-1:0]  buf_q, buf_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [SC_W-1:0]   sym_count_q, sym_count_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic              success_q, success_d;
  logic              fail_q, fail_d;
  logic [FC_W-1:0]   fail_count_q, fail_count_d;
`ifdef KEY_CHECKER_CONST_TIME_EN
  logic              mism_q, mism_d;
`endif

  logic [SYM_W-1:0]  cur_buf, cur_key;
  logic              cur_mism, sym_done, last_sym, last_rx;
  logic              finish, attempt_bad, lock_due;
  logic              lk_start, lk_active, lk_done;

  lockout_timer #(
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) u_lockout_timer (
    .clk   (clk),
    .rst   (rst),
    .start (lk_start),
    .active(lk_active),
    .done  (lk_done)
  );

  // Comparator: select the symbol under test and decide when the attempt ends.
  always_comb begin
    cur_buf = '0;
    cur_key = '0;
    for (int i = 0; i < NUM_SYMS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_buf = buf_q[i*SYM_W +: SYM_W];
        cur_key = key_q[i*SYM_W +: SYM_W];
      end
    end
    cur_mism = (cur_buf != cur_key);
    sym_done = (sub_q == SUB_W'(CYCLES_PER_SYM - 1));
    last_sym = (idx_q == IDX_W'(NUM_SYMS - 1));
    last_rx  = bus.sym_valid && (sym_count_q == SC_W'(NUM_SYMS - 1));
    lock_due = (MAX_FAILS != 0) && (fail_count_q == FC_W'(MAX_FAILS));
`ifdef KEY_CHECKER_CONST_TIME_EN
    attempt_bad = mism_q | cur_mism;
    finish      = sym_done && last_sym;
`else
    attempt_bad = cur_mism;
    finish      = sym_done && (cur_mism || last_sym);
`endif
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RECEIVE: if (last_rx)              state_d = COMPARE;
      COMPARE: if (finish)               state_d = RESULT;
      RESULT:  if (bus.ack)              state_d = lock_due ? LOCKOUT : RECEIVE;
      LOCKOUT: if (lk_done || !lk_active) state_d = RECEIVE;
      default:                           state_d = RECEIVE;
    endcase
  end

  // FSM outputs and datapath updates (buffer, counters, result flags).
  always_comb begin
    buf_d        = buf_q;
    key_d        = key_q;
    sym_count_d  = sym_count_q;
    idx_d        = idx_q;
    sub_d        = sub_q;
    success_d    = success_q;
    fail_d       = fail_q;
    fail_count_d = fail_count_q;
    lk_start     = 1'b0;
`ifdef KEY_CHECKER_CONST_TIME_EN
    mism_d       = mism_q;
`endif
    case (state_q)
      RECEIVE: begin
        if (bus.sym_valid) begin
          for (int i = 0; i < NUM_SYMS; i++) begin
            if (sym_count_q == SC_W'(i)) buf_d[i*SYM_W +: SYM_W] = bus.sym;
          end
          sym_count_d = sym_count_q + SC_W'(1);
        end
        if (last_rx) begin
          // Key is frozen here so later switch changes cannot affect this attempt.
          key_d = bus.key;
          idx_d = '0;
          sub_d = '0;
`ifdef KEY_CHECKER_CONST_TIME_EN
          mism_d = 1'b0;
`endif
        end
      end
      COMPARE: begin
        if (finish) begin
          success_d = !attempt_bad;
          fail_d    = attempt_bad;
          if (attempt_bad) begin
            if (fail_count_q != FC_W'(MAX_FAILS)) fail_count_d = fail_count_q + FC_W'(1);
          end else begin
            fail_count_d = '0;
          end
        end else if (sym_done) begin
          sub_d = '0;
          idx_d = idx_q + IDX_W'(1);
`ifdef KEY_CHECKER_CONST_TIME_EN
          mism_d = attempt_bad;
`endif
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
      RESULT: begin
        if (bus.ack) begin
          success_d   = 1'b0;
          fail_d      = 1'b0;
          sym_count_d = '0;
          lk_start    = lock_due;
        end
      end
      LOCKOUT: begin
        if (lk_done || !lk_active) fail_count_d = '0;
      end
      default: ;
    endcase
  end

  // State and datapath registers, all cleared by asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RECEIVE;
      buf_q        <= '0;
      key_q        <= '0;
      sym_count_q  <= '0;
      idx_q        <= '0;
      sub_q        <= '0;
      success_q    <= 1'b0;
      fail_q       <= 1'b0;
      fail_count_q <= '0;
`ifdef KEY_CHECKER_CONST_TIME_EN
      mism_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      key_q        <= key_d;
      sym_count_q  <= sym_count_d;
      idx_q        <= idx_d;
      sub_q        <= sub_d;
      success_q    <= success_d;
      fail_q       <= fail_d;
      fail_count_q <= fail_count_d;
`ifdef KEY_CHECKER_CONST_TIME_EN
      mism_q       <= mism_d;
`endif
    end
  end

  assign bus.success    = success_q;
  assign bus.fail       = fail_q;
  assign bus.busy       = (state_q == COMPARE);
  assign bus.locked     = (state_q == LOCKOUT);
  assign bus.sym_count  = sym_count_q;
  assign bus.fail_count = fail_count_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_key_checker_seq.sv
// Bench for key_checker_seq: randomized and directed attempts checked
// against a behavioural model of the attempt outcome, result latency,
// fail streak and lockout length.
module tb_key_checker_seq;
  import key_checker_pkg::*;

  localparam int N    = 4;
  localparam int W    = 2;
  localparam int CPS  = 4;
  localparam int MF   = 3;
  localparam int LOCK = 20;
  localparam int KW   = N * W;
  localparam int SC_W = cnt_w(N);
  localparam int FC_W = cnt_w(MF);

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;

  key_checker_seq_if #(.NUM_SYMS(N), .SYM_W(W), .MAX_FAILS(MF)) bus ();

  key_checker_seq #(
    .NUM_SYMS      (N),
    .SYM_W         (W),
    .CYCLES_PER_SYM(CPS),
    .MAX_FAILS     (MF),
    .LOCKOUT_CYCLES(LOCK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // Clock
  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_fc   = 0;
  bit const_time;
  logic [1:0] exp_q[$];   // expected {success, fail} per attempt

  task automatic check_all_zero(input string name);
    logic [8:0] obs;
    obs = {bus.success, bus.fail, bus.busy, bus.locked, bus.sym_count, bus.fail_count};
    n_checks++;
    if (obs !== 9'd0) begin
      n_fail++;
      $display("FAIL %s: outputs got %b expected all zero", name, obs);
    end
  endtask

  task automatic test_reset();
    bus.sym_valid = 1'b0;
    bus.sym       = '0;
    bus.key       = '0;
    bus.ack       = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_during");
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset_after");
    exp_fc = 0;
  endtask

  // One attempt: enter symbols s against key k, then follow busy/success/fail
  // cycle by cycle up to one cycle past the expected result edge.
  task automatic run_attempt(input logic [KW-1:0] k, input logic [KW-1:0] s, input bit change_key);
    int first_bad;
    int lat;
    bit bad;
    logic [2:0] obs, expv;
    logic [1:0] res_exp;
    bus.key = k;
    first_bad = -1;
    for (int i = 0; i < N; i++)
      if (first_bad < 0 && s[i*W +: W] != k[i*W +: W]) first_bad = i;
    bad = (first_bad >= 0);
    lat = (bad && !const_time) ? (first_bad + 1) * CPS : N * CPS;
    exp_q.push_back(bad ? 2'b01 : 2'b10);
    if (bad) exp_fc = (exp_fc < MF) ? exp_fc + 1 : MF;
    else     exp_fc = 0;

    for (int i = 0; i < N; i++) begin
      bus.sym_valid = 1'b1;
      bus.sym       = s[i*W +: W];
      @(negedge clk);
    end
    bus.sym_valid = 1'b0;

    n_checks++;
    if (bus.sym_count !== SC_W'(N)) begin
      n_fail++;
      $display("FAIL sym_count_full: got %0d expected %0d", bus.sym_count, N);
    end

    for (int kk = 0; kk <= lat + 1; kk++) begin
      if (change_key && kk == 1) bus.key = ~k;
      obs  = {bus.busy, bus.success, bus.fail};
      expv = {kk < lat, (kk >= lat) && !bad, (kk >= lat) && bad};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL timing T0+%0d: {busy,success,fail} got %b expected %b (key %h syms %h)",
                 kk, obs, expv, k, s);
      end
      if (kk <= lat) @(negedge clk);
    end

    n_checks++;
    if (bus.fail_count !== FC_W'(exp_fc)) begin
      n_fail++;
      $display("FAIL fail_count: got %0d expected %0d", bus.fail_count, exp_fc);
    end
    res_exp = exp_q.pop_front();
    n_checks++;
    if ({bus.success, bus.fail} !== res_exp) begin
      n_fail++;
      $display("FAIL result_held: got %b expected %b", {bus.success, bus.fail}, res_exp);
    end
  endtask

  // Acknowledge the result; if the fail streak is full, measure the lockout.
  task automatic do_ack(input bit with_sym);
    bit lock_exp;
    int cnt;
    lock_exp = (exp_fc == MF);
    bus.ack       = 1'b1;
    bus.sym_valid = with_sym;
    bus.sym       = W'($urandom_range(0, (1 << W) - 1));
    @(negedge clk);
    bus.ack       = 1'b0;
    bus.sym_valid = 1'b0;
    n_checks++;
    if ({bus.success, bus.fail, bus.locked, bus.sym_count} !== {2'b00, lock_exp, SC_W'(0)}) begin
      n_fail++;
      $display("FAIL after_ack: {succ,fail,locked,sym_count} got %b expected %b",
               {bus.success, bus.fail, bus.locked, bus.sym_count}, {2'b00, lock_exp, SC_W'(0)});
    end
    if (lock_exp) begin
      cnt = 0;
      while (bus.locked === 1'b1 && cnt < LOCK + 5) begin
        cnt++;
        bus.sym_valid = 1'($urandom_range(0, 1));
        bus.sym       = W'($urandom_range(0, (1 << W) - 1));
        @(negedge clk);
        n_checks++;
        if (bus.sym_count !== SC_W'(0)) begin
          n_fail++;
          $display("FAIL lockout_sym_count: got %0d expected 0", bus.sym_count);
        end
      end
      bus.sym_valid = 1'b0;
      n_checks++;
      if (cnt != LOCK) begin
        n_fail++;
        $display("FAIL lockout_len: got %0d cycles expected %0d", cnt, LOCK);
      end
      exp_fc = 0;
      n_checks++;
      if (bus.fail_count !== FC_W'(0)) begin
        n_fail++;
        $display("FAIL lockout_fc_clear: got %0d expected 0", bus.fail_count);
      end
    end
  endtask

  task automatic test_match();
    run_attempt(8'hE4, 8'hE4, 1'b0);
    do_ack(1'b0);
  endtask

  task automatic test_mismatch();
    run_attempt(8'hE4, 8'hE7, 1'b0);  // 3,1,2,3
    do_ack(1'b0);
    run_attempt(8'hE4, 8'hC4, 1'b0);  // 0,1,0,3
    do_ack(1'b0);
  endtask

  task automatic test_lockout();
    run_attempt(8'hE4, 8'hE4, 1'b0);
    do_ack(1'b0);
    for (int a = 0; a < MF; a++) begin
      run_attempt(8'hE4, 8'hE4 ^ KW'($urandom_range(1, 255)), 1'b0);
      do_ack(1'b0);
    end
    run_attempt(8'hE4, 8'hE4, 1'b0);
    do_ack(1'b0);
  endtask

  task automatic test_key_change_and_ack_sym();
    run_attempt(8'hE4, 8'hE4, 1'b1);
    do_ack(1'b1);
    run_attempt(8'h1B, 8'h13, 1'b1);
    do_ack(1'b1);
  endtask

  task automatic test_random();
    logic [KW-1:0] k, s;
    for (int r = 0; r < 12; r++) begin
      k = KW'($urandom);
      s = ($urandom_range(0, 1) == 1) ? k : KW'($urandom);
      run_attempt(k, s, 1'($urandom_range(0, 1)));
      do_ack(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_compare();
    bus.key = 8'hE4;
    for (int i = 0; i < N; i++) begin
      bus.sym_valid = 1'b1;
      bus.sym       = W'(i);
      @(negedge clk);
    end
    bus.sym_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("reset_mid_compare");
    @(negedge clk);
    rst = 1'b1;
    exp_fc = 0;
    run_attempt(8'hE4, 8'hE4, 1'b0);
    do_ack(1'b0);
  endtask

  task automatic test_reset_mid_lockout();
    while (exp_fc < MF) begin
      run_attempt(8'hE4, 8'hE5, 1'b0);
      if (exp_fc < MF) do_ack(1'b0);
    end
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_locked: got %b expected 1", bus.locked);
    end
    rst = 1'b0;
    #1;
    check_all_zero("reset_mid_lockout");
    @(negedge clk);
    rst = 1'b1;
    exp_fc = 0;
    run_attempt(8'hE4, 8'hE4, 1'b0);
    do_ack(1'b0);
  endtask

  initial begin
`ifdef KEY_CHECKER_CONST_TIME_EN
    const_time = 1'b1;
`else
    const_time = 1'b0;
`endif
    test_reset();
    test_match();
    test_mismatch();
    test_lockout();
    test_key_change_and_ack_sym();
    test_random();
    test_reset_mid_compare();
    test_reset_mid_lockout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case a wait never resolves.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $finish;
  end

endmodule
